// File: rtl/instr_fetch_unit.sv
// Fetch stage: single-outstanding imem reads, registered instruction/PC handed to decode via valid/ready.
// Latency imem_req->instr_valid = ack latency + 1; no new fetch while the held instruction awaits instr_ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        squash, squash_n;
    logic        halt_flag, halt_flag_n;
    logic [31:0] instruction_n, instr_pc_n;
    logic        instr_valid_n, halted_n;

    // FETCH is the reset state, so the strobe is masked while rst is held.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            halt_flag   <= 1'b0;
            instruction <= 32'd0;
            instr_pc    <= 32'd0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            squash      <= squash_n;
            halt_flag   <= halt_flag_n;
            instruction <= instruction_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= instr_valid_n;
            halted      <= halted_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        squash_n      = squash;
        halt_flag_n   = halt_flag;
        instruction_n = instruction;
        instr_pc_n    = instr_pc;
        instr_valid_n = instr_valid;
        halted_n      = halted;
        unique case (state)
            FETCH: begin
                state_n = WAIT;
                // The request at the old pc is already on the bus; its response must be dropped.
                if (redirect_valid) begin
                    pc_n     = redirect_pc;
                    squash_n = 1'b1;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (squash || redirect_valid) begin
                        squash_n = 1'b0;
                        state_n  = FETCH;
                        if (redirect_valid) pc_n = redirect_pc;
                    end else begin
                        instruction_n = imem_rdata;
                        instr_pc_n    = pc;
                        instr_valid_n = 1'b1;
                        pc_n          = pc + PC_STEP;
                        halt_flag_n   = (imem_rdata[31:26] == HALT_OP);
                        state_n       = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_n     = redirect_pc;
                    squash_n = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_n          = redirect_pc;
                    instr_valid_n = 1'b0;
                    halt_flag_n   = 1'b0;
                    state_n       = FETCH;
                end else if (instr_ready) begin
                    instr_valid_n = 1'b0;
                    if (halt_flag) begin
                        halted_n = 1'b1;
                        state_n  = HALT;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            HALT: begin
                state_n = HALT;
            end
            default: state_n = FETCH;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs driven and outputs sampled 2ns after each rising edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ack       (imem_ack),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; imem_rdata = 32'd0; imem_ack = 1'b0;
        instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        step(); step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // 1: basic fetch, ack one cycle after request
        rst = 1'b0; #1;
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'd0);
        step();
        chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h3C220004;
        step();
        imem_ack = 1'b0;
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instruction, 32'h3C220004);
        chk("t1_ipc", instr_pc, 32'd0);
        step();
        chk("t1_next_req", {31'd0, imem_req}, 32'd1);
        chk("t1_next_addr", imem_addr, 32'd1);

        // 2: backpressure in HOLD
        instr_ready = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = 32'h11111111;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", {31'd0, instr_valid}, 32'd1);
            chk("t2_instr", instruction, 32'h11111111);
            chk("t2_ipc", instr_pc, 32'd1);
            chk("t2_req", {31'd0, imem_req}, 32'd0);
            step();
        end
        chk("t2_still_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        step();
        chk("t2_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("t2_next_req", {31'd0, imem_req}, 32'd1);
        chk("t2_next_addr", imem_addr, 32'd2);

        // 3: redirect in WAIT, ack latency 3
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("t3_wait_req", {31'd0, imem_req}, 32'd0);
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_ack = 1'b0;
        chk("t3_no_valid", {31'd0, instr_valid}, 32'd0);
        chk("t3_no_stale", instruction, 32'h11111111);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h40);
        instr_ready = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = 32'h22222222;
        step();
        imem_ack = 1'b0;
        chk("t3_valid", {31'd0, instr_valid}, 32'd1);
        chk("t3_ipc", instr_pc, 32'h40);
        chk("t3_instr", instruction, 32'h22222222);

        // 4: redirect in HOLD with ready, then redirect coinciding with ack
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        chk("t4_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h10);
        step();
        imem_ack = 1'b1; imem_rdata = 32'h33333333;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        chk("t4b_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4b_instr", instruction, 32'h22222222);
        chk("t4b_req", {31'd0, imem_req}, 32'd1);
        chk("t4b_addr", imem_addr, 32'h20);

        // 5: HALT opcode
        instr_ready = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = 32'hFC000000;
        step();
        imem_ack = 1'b0;
        chk("t5_valid", {31'd0, instr_valid}, 32'd1);
        chk("t5_instr", instruction, 32'hFC000000);
        chk("t5_not_halted", {31'd0, halted}, 32'd0);
        instr_ready = 1'b1;
        step();
        chk("t5_halted", {31'd0, halted}, 32'd1);
        chk("t5_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("t5_req", {31'd0, imem_req}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_halt_req", {31'd0, imem_req}, 32'd0);
            chk("t5_halt_hold", {31'd0, halted}, 32'd1);
            step();
        end
        rst = 1'b1; #1;
        chk("t5_rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0; #1;
        chk("t5_restart_req", {31'd0, imem_req}, 32'd1);
        chk("t5_restart_addr", imem_addr, 32'd0);

        // 6: wrap at 0xFFFFFFFF, then async reset mid-WAIT
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
        step();
        redirect_valid = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h44444444;
        step();
        imem_ack = 1'b0;
        chk("t6_squash_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_addr_ff", imem_addr, 32'hFFFFFFFF);
        step();
        imem_ack = 1'b1; imem_rdata = 32'h55555555;
        step();
        imem_ack = 1'b0;
        chk("t6_ipc", instr_pc, 32'hFFFFFFFF);
        chk("t6_instr", instruction, 32'h55555555);
        step();
        chk("t6_wrap_addr", imem_addr, 32'd0);
        chk("t6_wrap_req", {31'd0, imem_req}, 32'd1);
        step();
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_rst_instr", instruction, 32'd0);
        chk("t6_rst_ipc", instr_pc, 32'd0);
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("t6_rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0; #1;
        chk("t6_restart_req", {31'd0, imem_req}, 32'd1);
        chk("t6_restart_addr", imem_addr, 32'd0);
        step();
        imem_ack = 1'b1; imem_rdata = 32'h66666666;
        step();
        imem_ack = 1'b0;
        chk("t6_final_valid", {31'd0, instr_valid}, 32'd1);
        chk("t6_final_ipc", instr_pc, 32'd0);
        chk("t6_final_instr", instruction, 32'h66666666);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
